// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a fixed 16-entry note ROM and drives the divider and gate of the
// downstream tone generator, with start/stop, looping, rests and an inter-note silent gap.
module melody_sequencer #(
    parameter int TICK  = 6250000,
    parameter int GAP   = 500000,
    parameter int DIV_W = 17
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSTART,
    input  logic             iSTOP,
    input  logic             iLOOP,
    output logic [DIV_W-1:0] oDIV,
    output logic             oGATE,
    output logic             oBUSY,
    output logic             oSTEP,
    output logic [3:0]       oIDX
);

    localparam int CNT_W = $clog2(16 * TICK);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY
    } state_t;

    state_t           r_state, w_nextState;
    logic [3:0]       r_idx, w_nextIdx;
    logic [CNT_W-1:0] r_count, w_nextCount;
    logic [CNT_W-1:0] r_last, w_nextLast;
    logic [DIV_W-1:0] r_div, w_nextDiv;
    logic             r_gate, w_nextGate;
    logic             r_step, w_nextStep;

    logic [7:0]       w_entry;
    logic [3:0]       w_code;
    logic [3:0]       w_dur;
    logic             w_isEnd;
    logic [DIV_W-1:0] w_noteDiv;

    // Song ROM, entry = {code, dur}; everything past entry 4 is END.
    always_comb begin
        case (r_idx)
            4'd0:    w_entry = 8'h11;
            4'd1:    w_entry = 8'h51;
            4'd2:    w_entry = 8'h81;
            4'd3:    w_entry = 8'h00;
            4'd4:    w_entry = 8'hA3;
            default: w_entry = 8'hD0;
        endcase
    end

    assign w_code  = w_entry[7:4];
    assign w_dur   = w_entry[3:0];
    assign w_isEnd = (w_code >= 4'd13);

    always_comb begin
        case (w_code)
            4'd1:    w_noteDiv = DIV_W'(95556);
            4'd2:    w_noteDiv = DIV_W'(90193);
            4'd3:    w_noteDiv = DIV_W'(85131);
            4'd4:    w_noteDiv = DIV_W'(80353);
            4'd5:    w_noteDiv = DIV_W'(75843);
            4'd6:    w_noteDiv = DIV_W'(71586);
            4'd7:    w_noteDiv = DIV_W'(67568);
            4'd8:    w_noteDiv = DIV_W'(63776);
            4'd9:    w_noteDiv = DIV_W'(60196);
            4'd10:   w_noteDiv = DIV_W'(56818);
            4'd11:   w_noteDiv = DIV_W'(53629);
            4'd12:   w_noteDiv = DIV_W'(50619);
            default: w_noteDiv = '0;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        w_nextCount = r_count;
        w_nextLast  = r_last;
        w_nextDiv   = r_div;
        w_nextGate  = r_gate;
        w_nextStep  = 1'b0;

        case (r_state)
            IDLE: begin
                w_nextDiv   = '0;
                w_nextGate  = 1'b0;
                w_nextCount = '0;
                if (iSTART && !iSTOP) begin
                    w_nextState = FETCH;
                    w_nextIdx   = 4'd0;
                end
            end
            FETCH: begin
                w_nextGate = 1'b0;
                if (w_isEnd) begin
                    if (iLOOP) begin
                        w_nextIdx = 4'd0;
                    end else begin
                        w_nextState = IDLE;
                        w_nextDiv   = '0;
                    end
                end else begin
                    w_nextState = PLAY;
                    w_nextDiv   = w_noteDiv;
                    w_nextCount = '0;
                    // Store L-1 so PLAY only needs equality compares.
                    w_nextLast  = CNT_W'((32'(w_dur) + 32'd1) * 32'(TICK) - 32'd1);
                    w_nextStep  = 1'b1;
                    w_nextGate  = (w_code != 4'd0);
                end
            end
            PLAY: begin
                w_nextCount = r_count + 1'b1;
                if (r_count == r_last - CNT_W'(GAP)) begin
                    w_nextGate = 1'b0;
                end
                if (r_count == r_last) begin
                    w_nextState = FETCH;
                    w_nextIdx   = r_idx + 4'd1;
                    w_nextGate  = 1'b0;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        // Stop wins over every other transition.
        if (iSTOP && (r_state != IDLE)) begin
            w_nextState = IDLE;
            w_nextDiv   = '0;
            w_nextGate  = 1'b0;
            w_nextStep  = 1'b0;
            w_nextCount = '0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= IDLE;
            r_idx   <= 4'd0;
            r_count <= '0;
            r_last  <= '0;
            r_div   <= '0;
            r_gate  <= 1'b0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_idx   <= w_nextIdx;
            r_count <= w_nextCount;
            r_last  <= w_nextLast;
            r_div   <= w_nextDiv;
            r_gate  <= w_nextGate;
            r_step  <= w_nextStep;
        end
    end

    assign oDIV  = r_div;
    assign oGATE = r_gate;
    assign oBUSY = (r_state != IDLE);
    assign oSTEP = r_step;
    assign oIDX  = r_idx;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer with TICK=10, GAP=2: expected note starts and
// returns to idle are queued up front; a monitor matches them against DUT events.
module tb_melody_sequencer;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iSTART;
    logic        iSTOP;
    logic        iLOOP;
    logic [16:0] oDIV;
    logic        oGATE;
    logic        oBUSY;
    logic        oSTEP;
    logic [3:0]  oIDX;

    melody_sequencer #(
        .TICK (10),
        .GAP  (2),
        .DIV_W(17)
    ) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iSTART(iSTART),
        .iSTOP (iSTOP),
        .iLOOP (iLOOP),
        .oDIV  (oDIV),
        .oGATE (oGATE),
        .oBUSY (oBUSY),
        .oSTEP (oSTEP),
        .oIDX  (oIDX)
    );

    always #5 iCLK = ~iCLK;

    // delta: cycles since previous event or start request; gateHigh: gate-high cycles in that span.
    typedef struct {
        bit isIdle;
        int div;
        bit gate;
        int idx;
        int delta;
        int gateHigh;
    } expT;

    expT expQ[$];
    int  checkCount = 0;
    int  passCount  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic void expectStep(int div, bit gate, int idx, int delta, int gateHigh);
        expQ.push_back('{1'b0, div, gate, idx, delta, gateHigh});
    endfunction

    function automatic void expectIdle(int idx, int delta, int gateHigh);
        expQ.push_back('{1'b1, 0, 1'b0, idx, delta, gateHigh});
    endfunction

    // Drive inputs just after a rising edge, hold for one edge, then release the pulses.
    task automatic applyStimulus(input logic start, input logic stop, input logic loop, input logic rst);
        iSTART = start;
        iSTOP  = stop;
        iLOOP  = loop;
        iRST   = rst;
        @(posedge iCLK);
        #1;
        iSTART = 1'b0;
        iSTOP  = 1'b0;
        iRST   = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    initial begin : monitor
        int  cyc;
        int  anchor;
        int  gateCnt;
        int  evNum;
        bit  prevBusy;
        expT e;
        cyc      = 0;
        anchor   = 0;
        gateCnt  = 0;
        evNum    = 0;
        prevBusy = 1'b0;
        forever begin
            @(negedge iCLK);
            cyc++;
            if (oSTEP || (prevBusy && !oBUSY)) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected event at cycle %0d: step=%0b busy=%0b idx=%0d, expected none",
                             cyc, oSTEP, oBUSY, oIDX);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("ev%0d kind(idle)", evNum), int'(!oSTEP), int'(e.isIdle));
                    checkOutput($sformatf("ev%0d oDIV", evNum), int'(oDIV), e.div);
                    checkOutput($sformatf("ev%0d oGATE", evNum), int'(oGATE), int'(e.gate));
                    checkOutput($sformatf("ev%0d oIDX", evNum), int'(oIDX), e.idx);
                    checkOutput($sformatf("ev%0d cycles since prev", evNum), cyc - anchor, e.delta);
                    checkOutput($sformatf("ev%0d gate-high cycles", evNum), gateCnt, e.gateHigh);
                end
                evNum++;
                anchor  = cyc;
                gateCnt = 0;
            end
            if (iSTART && !iSTOP && !iRST && !oBUSY) begin
                anchor  = cyc;
                gateCnt = 0;
            end
            if (oGATE) gateCnt++;
            prevBusy = oBUSY;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        iRST   = 1'b1;
        iSTART = 1'b0;
        iSTOP  = 1'b0;
        iLOOP  = 1'b0;
        idleCycles(2);
        checkOutput("reset oDIV", int'(oDIV), 0);
        checkOutput("reset oGATE", int'(oGATE), 0);
        checkOutput("reset oBUSY", int'(oBUSY), 0);
        checkOutput("reset oSTEP", int'(oSTEP), 0);
        checkOutput("reset oIDX", int'(oIDX), 0);
        iRST = 1'b0;
        idleCycles(2);

        $display("[TB] full song, no loop, stray start during C4");
        expectStep(95556, 1'b1, 0, 2, 0);
        expectStep(75843, 1'b1, 1, 21, 18);
        expectStep(63776, 1'b1, 2, 21, 18);
        expectStep(0, 1'b0, 3, 21, 18);
        expectStep(56818, 1'b1, 4, 11, 0);
        expectIdle(5, 41, 38);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(115);
        checkOutput("song end oBUSY", int'(oBUSY), 0);
        checkOutput("song end oDIV", int'(oDIV), 0);

        $display("[TB] start and stop together in idle");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idleCycles(3);
        checkOutput("start+stop oBUSY", int'(oBUSY), 0);
        checkOutput("start+stop oIDX held", int'(oIDX), 5);

        $display("[TB] stop during E4, then restart");
        expectStep(95556, 1'b1, 0, 2, 0);
        expectStep(75843, 1'b1, 1, 21, 18);
        expectIdle(1, 6, 6);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(27);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(3);
        expectStep(95556, 1'b1, 0, 2, 0);
        expectIdle(0, 4, 4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(3);

        $display("[TB] looping playback");
        expectStep(95556, 1'b1, 0, 2, 0);
        expectStep(75843, 1'b1, 1, 21, 18);
        expectStep(63776, 1'b1, 2, 21, 18);
        expectStep(0, 1'b0, 3, 21, 18);
        expectStep(56818, 1'b1, 4, 11, 0);
        expectStep(95556, 1'b1, 0, 42, 38);
        expectStep(75843, 1'b1, 1, 21, 18);
        expectIdle(1, 6, 6);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        idleCycles(143);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        idleCycles(3);
        iLOOP = 1'b0;

        $display("[TB] reset during G4, then restart");
        expectStep(95556, 1'b1, 0, 2, 0);
        expectStep(75843, 1'b1, 1, 21, 18);
        expectStep(63776, 1'b1, 2, 21, 18);
        expectIdle(0, 6, 6);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(48);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("post-reset oSTEP", int'(oSTEP), 0);
        idleCycles(2);
        expectStep(95556, 1'b1, 0, 2, 0);
        expectIdle(0, 4, 4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(3);

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
